// File: rtl/sine_stim_ctrl.sv
// -----------------------------------------------------------------------------
// sine_stim_ctrl
//   Sequencer for an enable-gated sine test source. Resets and primes the
//   generator pipeline, issues its clock-enable at a programmable rate in
//   bursts separated by idle gaps, stalls on downstream backpressure, and
//   marks the generator outputs that carry valid samples.
//
// Ports
//   clk_i          clock
//   rst_n_i        synchronous active-low reset
//   start_i        start pulse (latches config; honoured only when idle)
//   stop_i         abort to idle, highest priority
//   rate_i         enable period minus 1
//   burst_len_i    samples per burst (0 = continuous)
//   gap_i          idle cycles between bursts
//   num_bursts_i   bursts per run (0 = unlimited)
//   ready_i        downstream accepts a sample
//   gen_rst_o      active-high generator reset
//   gen_ena_o      generator clock-enable
//   valid_o        generator output holds a new valid sample
//   sop_o / eop_o  first / last sample of a burst (qualify valid_o)
//   busy_o         sequencer not idle
//   burst_cnt_o    bursts completed this run
//   stall_cnt_o    backpressure stall cycles
//
// Build option
//   SINE_STIM_CTRL_STATS_EN  when defined, stall_cnt_o counts RUN cycles with
//                            a due tick and ready_i low (saturating, cleared
//                            on start); otherwise stall_cnt_o is tied to 0.
// -----------------------------------------------------------------------------
module sine_stim_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [CNT_WIDTH-1:0] rate_i,
    input  logic [CNT_WIDTH-1:0] burst_len_i,
    input  logic [CNT_WIDTH-1:0] gap_i,
    input  logic [CNT_WIDTH-1:0] num_bursts_i,
    input  logic                 ready_i,
    output logic                 gen_rst_o,
    output logic                 gen_ena_o,
    output logic                 valid_o,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] burst_cnt_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int PW = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRST,
        S_PRIME,
        S_RUN,
        S_GAP
    } state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] rate_q, burst_len_q, gap_q, num_bursts_q;
    logic [CNT_WIDTH-1:0] rate_cnt_q, samp_cnt_q, gap_cnt_q, burst_cnt_q;
    logic [PW-1:0]        prime_cnt_q;
    logic                 valid_q, sop_q, eop_q;

    logic tick, prime_ena, run_ena, first_samp, last_samp, last_burst;

    // The enable must react to ready_i in the same cycle so a stalled tick
    // fires on the very cycle ready returns; stop_i suppresses it so an
    // aborted cycle never advances the generator.
    assign tick       = (rate_cnt_q == rate_q);
    assign prime_ena  = (state_q == S_PRIME) && tick && !stop_i;
    assign run_ena    = (state_q == S_RUN) && tick && ready_i && !stop_i;
    assign first_samp = (samp_cnt_q == '0);
    assign last_samp  = (burst_len_q != '0) && (samp_cnt_q == burst_len_q - 1'b1);
    assign last_burst = (num_bursts_q != '0) && (burst_cnt_q == num_bursts_q - 1'b1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            rate_q       <= '0;
            burst_len_q  <= '0;
            gap_q        <= '0;
            num_bursts_q <= '0;
            rate_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            prime_cnt_q  <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
        end else if (stop_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            // Markers trail the enable by one cycle, lining up with the
            // generator output update.
            valid_q <= run_ena;
            sop_q   <= run_ena && first_samp;
            eop_q   <= run_ena && last_samp;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rate_q       <= rate_i;
                        burst_len_q  <= burst_len_i;
                        gap_q        <= gap_i;
                        num_bursts_q <= num_bursts_i;
                        rate_cnt_q   <= '0;
                        samp_cnt_q   <= '0;
                        gap_cnt_q    <= '0;
                        burst_cnt_q  <= '0;
                        prime_cnt_q  <= '0;
                        state_q      <= S_GRST;
                    end
                end
                S_GRST: begin
                    rate_cnt_q  <= '0;
                    prime_cnt_q <= '0;
                    state_q     <= S_PRIME;
                end
                S_PRIME: begin
                    if (tick) begin
                        rate_cnt_q <= '0;
                        if (prime_cnt_q == PW'(PIPE_DEPTH - 1)) begin
                            state_q <= S_RUN;
                        end else begin
                            prime_cnt_q <= prime_cnt_q + 1'b1;
                        end
                    end else begin
                        rate_cnt_q <= rate_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        // A stalled tick holds the counter at rate until ready.
                        if (ready_i) begin
                            rate_cnt_q <= '0;
                            if (last_samp) begin
                                samp_cnt_q  <= '0;
                                burst_cnt_q <= burst_cnt_q + 1'b1;
                                if (last_burst) begin
                                    state_q <= S_IDLE;
                                end else if (gap_q != '0) begin
                                    gap_cnt_q <= '0;
                                    state_q   <= S_GAP;
                                end
                            end else if (burst_len_q != '0 || first_samp) begin
                                // Continuous mode parks the count at 1 so
                                // sop_o marks only the first sample.
                                samp_cnt_q <= samp_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        rate_cnt_q <= rate_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    // gap_q idle cycles plus the slot of the burst's last
                    // sample output, so valid_o is low gap+1 cycles.
                    if (gap_cnt_q == gap_q) begin
                        rate_cnt_q <= '0;
                        state_q    <= S_RUN;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gen_rst_o   = (state_q == S_GRST);
    assign gen_ena_o   = prime_ena || run_ena;
    assign valid_o     = valid_q;
    assign sop_o       = sop_q;
    assign eop_o       = eop_q;
    assign busy_o      = (state_q != S_IDLE);
    assign burst_cnt_o = burst_cnt_q;

`ifdef SINE_STIM_CTRL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (state_q == S_RUN) && tick && !ready_i && !stop_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (state_q == S_IDLE && start_i && !stop_i) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sine_stim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sine_stim_ctrl
//   Directed bench: each scenario captures per-cycle traces of the control
//   outputs (bit i = cycle i, cycle 0 = first cycle after the start edge) and
//   compares them with hand-derived patterns.
// -----------------------------------------------------------------------------
module tb_sine_stim_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ready = 1'b1;
    logic [CW-1:0] rate = '0, blen = '0, gap = '0, nbur = '0;
    logic          gen_rst, gen_ena, valid, sop, eop, busy;
    logic [CW-1:0] burst_cnt;
    logic [31:0]   stall_cnt;

    logic [31:0] tr_rst, tr_ena, tr_val, tr_sop, tr_eop, tr_busy;

    int n_err = 0;
    int n_chk = 0;

    sine_stim_ctrl #(.CNT_WIDTH(CW), .PIPE_DEPTH(3)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .rate_i      (rate),
        .burst_len_i (blen),
        .gap_i       (gap),
        .num_bursts_i(nbur),
        .ready_i     (ready),
        .gen_rst_o   (gen_rst),
        .gen_ena_o   (gen_ena),
        .valid_o     (valid),
        .sop_o       (sop),
        .eop_o       (eop),
        .busy_o      (busy),
        .burst_cnt_o (burst_cnt),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Pulse start with a configuration; returns 1 time unit into cycle 0.
    task automatic launch(input logic [CW-1:0] r, input logic [CW-1:0] b,
                          input logic [CW-1:0] g, input logic [CW-1:0] n);
        @(posedge clk); #1;
        rate = r; blen = b; gap = g; nbur = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Capture n cycles; ready low in [rlo_a, rlo_b], stop / reset in one cycle.
    task automatic capture(input int n, input int rlo_a, input int rlo_b,
                           input int stop_at, input int rst_at);
        tr_rst = '0; tr_ena = '0; tr_val = '0; tr_sop = '0; tr_eop = '0; tr_busy = '0;
        for (int i = 0; i < n; i++) begin
            ready = !(i >= rlo_a && i <= rlo_b);
            stop  = (i == stop_at);
            rst_n = (i != rst_at);
            @(negedge clk);
            tr_rst[i]  = gen_rst;
            tr_ena[i]  = gen_ena;
            tr_val[i]  = valid;
            tr_sop[i]  = sop;
            tr_eop[i]  = eop;
            tr_busy[i] = busy;
            @(posedge clk); #1;
        end
        ready = 1'b1; stop = 1'b0; rst_n = 1'b1;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic check_two_bursts(input string tag);
        launch(16'd0, 16'd4, 16'd2, 16'd2);
        capture(20, -1, -1, -1, -1);
        check({tag, " gen_rst"}, tr_rst, 32'h0000_0001);
        check({tag, " ena"}, tr_ena, 32'h0000_78FE);
        check({tag, " valid"}, tr_val, 32'h0000_F1E0);
        check({tag, " sop"}, tr_sop, 32'h0000_1020);
        check({tag, " eop"}, tr_eop, 32'h0000_8100);
        check({tag, " busy"}, tr_busy, 32'h0000_7FFF);
        check({tag, " burst_cnt"}, 32'(burst_cnt), 32'd2);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              {26'd0, gen_rst, gen_ena, valid, sop, eop, busy}, 32'd0);
        check("reset burst_cnt", 32'(burst_cnt), 32'd0);
        check("reset stall_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two bursts of 4, gap 2, every-cycle rate
        check_two_bursts("t1");

        // rate=3, continuous
        launch(16'd3, 16'd0, 16'd0, 16'd0);
        capture(32, -1, -1, -1, -1);
        check("t2 ena", tr_ena, 32'h1111_1110);
        check("t2 valid", tr_val, 32'h2222_0000);
        check("t2 sop", tr_sop, 32'h0002_0000);
        check("t2 eop", tr_eop, 32'h0000_0000);
        check("t2 busy", tr_busy, 32'hFFFF_FFFF);
        do_stop();
        check("t2 busy after stop", 32'(busy), 32'd0);

        // rate=1, continuous, ready low for 5 cycles at a due tick
        launch(16'd1, 16'd0, 16'd0, 16'd0);
        capture(24, 10, 14, -1, -1);
        check("t3 ena", tr_ena, 32'h00AA_8154);
        check("t3 valid", tr_val, 32'h0055_0200);
`ifdef SINE_STIM_CTRL_STATS_EN
        check("t3 stall_cnt", stall_cnt, 32'd5);
`else
        check("t3 stall_cnt", stall_cnt, 32'd0);
`endif
        do_stop();

        // stop during PRIME after one enable
        launch(16'd0, 16'd4, 16'd2, 16'd2);
        capture(6, -1, -1, 2, -1);
        check("t4 gen_rst", tr_rst, 32'h0000_0001);
        check("t4 ena", tr_ena, 32'h0000_0002);
        check("t4 valid", tr_val, 32'h0000_0000);
        check("t4 busy", tr_busy, 32'h0000_0007);

        // restart after stop replays GRST and full priming
        check_two_bursts("t4 restart");

        // reset in the middle of burst 2
        launch(16'd0, 16'd4, 16'd2, 16'd2);
        capture(17, -1, -1, -1, 13);
        check("t5 ena", tr_ena, 32'h0000_38FE);
        check("t5 valid", tr_val, 32'h0000_31E0);
        check("t5 sop", tr_sop, 32'h0000_1020);
        check("t5 eop", tr_eop, 32'h0000_0100);
        check("t5 busy", tr_busy, 32'h0000_3FFF);
        check("t5 burst_cnt", 32'(burst_cnt), 32'd0);

        // single-sample bursts, no gap, three bursts
        launch(16'd1, 16'd1, 16'd0, 16'd3);
        capture(16, -1, -1, -1, -1);
        check("t6 ena", tr_ena, 32'h0000_1554);
        check("t6 valid", tr_val, 32'h0000_2A00);
        check("t6 sop", tr_sop, 32'h0000_2A00);
        check("t6 eop", tr_eop, 32'h0000_2A00);
        check("t6 busy", tr_busy, 32'h0000_1FFF);
        check("t6 burst_cnt", 32'(burst_cnt), 32'd3);

        // start and stop together in IDLE: stop wins, counters hold
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("t7 busy", 32'(busy), 32'd0);
        check("t7 gen_rst", 32'(gen_rst), 32'd0);
        check("t7 burst_cnt held", 32'(burst_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sine_stim_ctrl.md
# sine_stim_ctrl

Sequencer for the enable-gated sine test source in the FIR interpolator bench. Resets and primes the generator pipeline, issues its clock-enable at a programmable sample rate in bursts separated by idle gaps, stalls on downstream backpressure, and flags which generator outputs are valid samples with start/end-of-burst markers.

## Interface
- CNT_WIDTH, 16, width of rate, burst, gap and count fields
- PIPE_DEPTH, 3, enables needed before generator output holds sample 0
- clk_i  in  1  clock
- rst_n_i  in  1  reset; one clock; reset is synchronous and active-low
- start_i  in  1  start pulse; latches config, ignored unless IDLE
- stop_i  in  1  abort; to IDLE next edge, priority over all else
- rate_i  in  CNT_WIDTH  enable period minus 1 (0 = every cycle)
- burst_len_i  in  CNT_WIDTH  samples per burst (0 = continuous, no gaps)
- gap_i  in  CNT_WIDTH  idle cycles between bursts
- num_bursts_i  in  CNT_WIDTH  bursts per run (0 = unlimited)
- ready_i  in  1  downstream can accept a sample
- gen_rst_o  out  1  active-high reset to generator
- gen_ena_o  out  1  clock-enable to generator
- valid_o  out  1  generator output updated with a valid sample this cycle
- sop_o / eop_o  out  1 each  first / last sample of burst, qualify valid_o
- busy_o  out  1  state != IDLE
- burst_cnt_o  out  CNT_WIDTH  completed bursts this run
- stall_cnt_o  out  32  backpressure stall cycles (see Configuration)

## Operation
- States: IDLE, GRST, PRIME, RUN, GAP.
- IDLE: outputs low; start_i latches rate/burst_len/gap/num_bursts, clears counters, -> GRST.
- GRST: gen_rst_o=1 exactly one cycle -> PRIME.
- PRIME: rate counter runs; each tick asserts gen_ena_o (ready_i ignored); after PIPE_DEPTH ticks -> RUN, rate counter restarts at 0.
- RUN: tick = rate counter == latched rate. Tick with ready_i=1: gen_ena_o=1, sample counted, counter reloads 0. Tick with ready_i=0: counter holds at rate, no enable (stall), fires the first cycle ready_i=1.
- Burst end (sample count reaches burst_len, burst_len != 0): burst_cnt_o++; if num_bursts != 0 and burst_cnt_o reaches it -> IDLE; else gap != 0 -> GAP, gap == 0 -> stay RUN.
- GAP: count gap cycles, no enables, -> RUN with rate counter 0.
- valid_o, sop_o, eop_o registered from RUN enable; aligned with the generator's sine_o/cos_o update.
- Generator phase not reset between bursts; waveform continuous across gaps.
- stop_i any state (including GRST/PRIME): -> IDLE, gen_ena_o low same edge, no eop_o; burst_cnt_o holds until next start.
- rst_n_i low: all state/counters cleared, mid-operation included.
- All counters CNT_WIDTH bits unsigned; unlimited modes rely on wrap of burst_cnt_o only.

## Timing
- Reset values: gen_rst_o=0, gen_ena_o=0, valid_o=0, sop_o=0, eop_o=0, busy_o=0, burst_cnt_o=0, stall_cnt_o=0.
- start_i at edge N: GRST cycle N+1; busy_o high from N+1.
- First PRIME enable: rate+1 cycles after GRST; enables spaced rate+1 when unstalled.
- valid_o one cycle after its gen_ena_o; first valid sample = sin(0) = 0, cos = MAX.
- sop_o on burst's first valid, eop_o on last; both when burst_len=1.
- Last eop_o of run: state IDLE in the same cycle.
- start_i and stop_i together in IDLE: stop wins, stays IDLE.

## Configuration
- SINE_STIM_CTRL_STATS_EN defined: stall_cnt_o counts RUN cycles with a due tick and ready_i=0, saturates at 2^32-1, clears on start.
- Undefined: counter not built, stall_cnt_o tied 0.

## Test plan
- rate=0, burst_len=4, gap=2, num_bursts=2, ready=1: 1 gen_rst_o, 3 prime enables, valids in two groups of 4 separated by 3 non-valid cycles, sop/eop on 1st/4th, burst_cnt_o=2, IDLE.
- rate=3, burst_len=0, ready=1: gen_ena_o every 4th cycle, valid never stops, sample values follow sin(2πk/PHASE_MAX) from k=0.
- rate=1, ready_i low 5 cycles when tick due: no enable those cycles, enable cycle ready returns, no sample lost; stall_cnt_o=5 with macro, 0 without.
- stop_i during PRIME after 1 enable: IDLE next cycle, no valid_o; restart gives full GRST and 3 primes again.
- rst_n_i low mid-burst 2: all outputs reset values next edge; start after reset gives sop_o on first sample.
- burst_len=1, gap=0, num_bursts=3: three valids each with sop_o=eop_o=1, back-to-back at rate spacing.
